axi4_full_rd_dma: RTL and testbench
===================================

Name: axi4_full_rd_dma

Overview:
AXI4-Full read master (initiator) that pulls a linear region from an AXI4-Full slave memory and emits it as a ready/valid beat stream.
- Accepts one command at a time: start byte address plus total beat count.
- Splits the command into INCR bursts of at most MAX_BURST beats that never cross a 4 KiB boundary.
- Issues one AR at a time, with one burst outstanding.
- Sits between the NPU load path and the data-memory slave.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 1024, data beat width; power of two, 8..1024.
- ID_WIDTH, 4, AXI ID width.
- LEN_WIDTH, 8, AXI arlen width.
- CNT_WIDTH, 16, width of total-beat command count.
- MAX_BURST, 16, maximum beats per burst; 1..2^LEN_WIDTH.
- RD_ID, 0, constant arid value.

Ports:
- clk  in  1  clock
- rst  in  1  async active-high reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_addr  in  ADDR_WIDTH  start byte address, beat-aligned
- cmd_beats  in  CNT_WIDTH  total beats minus 1
- out_data  out  DATA_WIDTH  stream data
- out_last  out  1  final beat of whole command
- out_valid  out  1  stream valid
- out_ready  in  1  stream ready
- done  out  1  one-cycle pulse after command completes
- err  out  1  valid with done; any rresp != OKAY or rid mismatch during command
- m_arid  out  ID_WIDTH  read ID (RD_ID)
- m_araddr  out  ADDR_WIDTH  burst start address
- m_arburst  out  2  constant 2'b01 INCR
- m_arlen  out  LEN_WIDTH  burst beats minus 1
- m_arsize  out  3  constant log2(DATA_WIDTH/8)
- m_arvalid  out  1  AR valid
- m_arready  in  1  AR ready
- m_rid  in  ID_WIDTH  read ID
- m_rdata  in  DATA_WIDTH  read data
- m_rresp  in  2  read response
- m_rlast  in  1  last beat of burst
- m_rvalid  in  1  R valid
- m_rready  out  1  R ready

Behaviour:
- Reset (async, rst=1): all valids, cmd_ready, done, err and m_rready are 0; FSM goes to IDLE; counters clear. Reset mid-burst abandons the transfer; no recovery of outstanding R beats.
- FSM states IDLE -> AR -> R -> (AR | DONE) -> IDLE.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready:
  - latch addr and remaining = cmd_beats+1 (CNT_WIDTH+1 bits);
  - clear err_sticky;
  - go to AR next cycle.
- AR: m_arvalid=1, held stable until m_arready.
  - Burst beats b = min(remaining, MAX_BURST, (4096 - addr[11:0]) / (DATA_WIDTH/8)).
  - m_arlen = b-1 and m_araddr = addr, both registered on entry to AR.
  - On handshake: burst_cnt = b, then go to R.
- R: m_rready = out_ready; out_valid = m_rvalid; out_data = m_rdata. This is a combinational pass-through with zero added latency.
  - out_last = m_rvalid && burst_cnt==1 && remaining==1 (remaining decrements per beat).
  - On each R handshake:
    - decrement burst_cnt and remaining;
    - addr += DATA_WIDTH/8;
    - err_sticky |= (rresp!=0) || (rid!=RD_ID).
  - On the beat where burst_cnt==1: go to DONE if remaining becomes 0, else go to AR.
  - m_rlast is not used for control. Mismatch with burst_cnt==1 sets err_sticky.
- DONE: done=1 and err=err_sticky for one cycle, then IDLE. cmd_ready is 0 in DONE, so the minimum gap between commands is 1 cycle.
- AR valid never drops without handshake. out_valid follows m_rvalid; AXI stability rules pass through unchanged.
- Address wrap past 2^ADDR_WIDTH is unchecked (caller responsibility).
- A 4 KiB boundary split yields a burst shorter than MAX_BURST. Example: 128-B beats starting at 0xF80 give a 1-beat burst, then continue at 0x1000.
- cmd_beats=0 gives a single 1-beat burst with out_last on that beat.

Decomposition:
- Shared package axi4_pkg:
  - BURST_FIXED/INCR/WRAP encodings;
  - RESP_OKAY/EXOKAY/SLVERR/DECERR;
  - AXSIZE function log2(bytes);
  - AXI_4K_BOUNDARY=4096.
- One natural sub-module, axi4_burst_splitter: combinational min() of remaining, MAX_BURST and bytes-to-4K, returning beat count. All state stays in the top.

Test Plan:
- cmd_addr=0x0, cmd_beats=15, MAX_BURST=16 -> one AR (addr 0x0, len 15, size 7, burst 01); 16 out beats; out_last on beat 16; done=1, err=0.
- cmd_addr=0xF80, cmd_beats=3 -> AR1 (0xF80, len 0) then AR2 (0x1000, len 2); 4 beats total; single out_last.
- cmd_addr=0x0, cmd_beats=39 -> three ARs with len 15, 15, 7 at 0x0, 0x800, 0x1000; data order preserved; done after beat 40.
- Random out_ready=0 stalls and m_arready delayed 5 cycles -> m_rready mirrors out_ready; m_araddr/m_arlen stable while arvalid; no beat lost or duplicated.
- Slave returns rresp=2'b10 on beat 3 of 8 -> all 8 beats still forwarded; done with err=1; next command starts with err cleared.
- Assert rst in R state mid-burst -> next cycle m_arvalid=0, m_rready=0, cmd_ready=0; after release, cmd_ready=1.

Source files
------------

// File: rtl/axi4_pkg.sv
// Shared AXI4 encodings and helpers used by the read DMA and its burst splitter.
package axi4_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int AXI_4K_BOUNDARY = 4096;

    // AxSIZE encoding: log2 of the beat size in bytes (1..128).
    function automatic logic [2:0] axsize(input int bytes);
        logic [2:0] s;
        s = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if ((1 << i) == bytes) s = 3'(i);
        end
        return s;
    endfunction

endpackage

// File: rtl/axi4_burst_splitter.sv
// Beats for the next INCR burst: min(remaining, MAX_BURST, beats left before the 4 KiB page ends).
module axi4_burst_splitter
    import axi4_pkg::*;
#(
    parameter int DATA_WIDTH = 1024,
    parameter int CNT_WIDTH  = 16,
    parameter int LEN_WIDTH  = 8,
    parameter int MAX_BURST  = 16
) (
    input  logic [11:0]          addr_lo,
    input  logic [CNT_WIDTH:0]   remaining,
    output logic [LEN_WIDTH:0]   beats
);

    localparam int SHIFT = $clog2(DATA_WIDTH / 8);

    logic [12:0] to_4k;
    logic [31:0] room;
    logic [31:0] lim;

    assign to_4k = 13'(AXI_4K_BOUNDARY) - {1'b0, addr_lo};
    assign room  = 32'(to_4k >> SHIFT);

    always_comb begin
        lim = 32'(MAX_BURST);
        if (room < lim) lim = room;
        if (32'(remaining) < lim) lim = 32'(remaining);
        beats = (LEN_WIDTH + 1)'(lim);
    end

endmodule

// File: rtl/axi4_full_rd_dma.sv
// AXI4 read master: splits one linear command into 4 KiB-safe INCR bursts, one outstanding,
// and forwards R beats combinationally onto a ready/valid stream.
module axi4_full_rd_dma
    import axi4_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 1024,
    parameter int ID_WIDTH   = 4,
    parameter int LEN_WIDTH  = 8,
    parameter int CNT_WIDTH  = 16,
    parameter int MAX_BURST  = 16,
    parameter int RD_ID      = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [CNT_WIDTH-1:0]  cmd_beats,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  done,
    output logic                  err,
    output logic [ID_WIDTH-1:0]   m_arid,
    output logic [ADDR_WIDTH-1:0] m_araddr,
    output logic [1:0]            m_arburst,
    output logic [LEN_WIDTH-1:0]  m_arlen,
    output logic [2:0]            m_arsize,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    input  logic [ID_WIDTH-1:0]   m_rid,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    input  logic [1:0]            m_rresp,
    input  logic                  m_rlast,
    input  logic                  m_rvalid,
    output logic                  m_rready
);

    localparam int                    BYTES     = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(BYTES);
    localparam logic [CNT_WIDTH:0]    REM_ONE   = 1;
    localparam logic [LEN_WIDTH:0]    BEAT_ONE  = 1;

    typedef enum logic [1:0] {ST_IDLE, ST_AR, ST_R, ST_DONE} state_t;

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] addr, araddr_q, addr_inc;
    logic [CNT_WIDTH:0]    remaining, rem_dec, cmd_total, split_rem;
    logic [LEN_WIDTH:0]    burst_cnt, ar_beats, split_beats;
    logic [11:0]           split_addr;
    logic                  err_sticky, live;
    logic                  cmd_fire, r_fire, burst_end, beat_err;

    // Every channel transfers on the cycle where valid && ready is high at the rising edge;
    // a source never withdraws valid or changes its payload until that transfer happens.
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign r_fire    = m_rvalid && m_rready;
    assign burst_end = (burst_cnt == BEAT_ONE);
    assign addr_inc  = addr + ADDR_STEP;
    assign rem_dec   = remaining - REM_ONE;
    assign cmd_total = {1'b0, cmd_beats} + REM_ONE;
    assign beat_err  = (m_rresp != RESP_OKAY) || (m_rid != ID_WIDTH'(RD_ID)) || (m_rlast != burst_end);

    // From IDLE the next burst is sized off the incoming command, otherwise off the post-beat state.
    assign split_addr = (state == ST_IDLE) ? cmd_addr[11:0] : addr_inc[11:0];
    assign split_rem  = (state == ST_IDLE) ? cmd_total : rem_dec;

    axi4_burst_splitter #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH),
        .LEN_WIDTH  (LEN_WIDTH),
        .MAX_BURST  (MAX_BURST)
    ) u_splitter (
        .addr_lo   (split_addr),
        .remaining (split_rem),
        .beats     (split_beats)
    );

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (cmd_fire) state_next = ST_AR;
            ST_AR:   if (m_arready) state_next = ST_R;
            ST_R:    if (r_fire && burst_end) state_next = (rem_dec == '0) ? ST_DONE : ST_AR;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            live       <= 1'b0;
            addr       <= '0;
            araddr_q   <= '0;
            remaining  <= '0;
            burst_cnt  <= '0;
            ar_beats   <= '0;
            err_sticky <= 1'b0;
        end else begin
            state <= state_next;
            live  <= 1'b1;
            case (state)
                ST_IDLE: if (cmd_fire) begin
                    addr       <= cmd_addr;
                    araddr_q   <= cmd_addr;
                    remaining  <= cmd_total;
                    ar_beats   <= split_beats;
                    err_sticky <= 1'b0;
                end
                ST_AR: if (m_arready) burst_cnt <= ar_beats;
                ST_R: if (r_fire) begin
                    addr       <= addr_inc;
                    remaining  <= rem_dec;
                    burst_cnt  <= burst_cnt - BEAT_ONE;
                    err_sticky <= err_sticky | beat_err;
                    if (burst_end && rem_dec != '0) begin
                        araddr_q <= addr_inc;
                        ar_beats <= split_beats;
                    end
                end
                default: ;
            endcase
        end
    end

    // live keeps cmd_ready low while reset is asserted even though the state is already IDLE.
    assign cmd_ready = (state == ST_IDLE) && live;
    assign m_arvalid = (state == ST_AR);
    assign m_arid    = ID_WIDTH'(RD_ID);
    assign m_araddr  = araddr_q;
    assign m_arlen   = LEN_WIDTH'(ar_beats - BEAT_ONE);
    assign m_arburst = BURST_INCR;
    assign m_arsize  = axsize(BYTES);
    assign m_rready  = (state == ST_R) && out_ready;
    assign out_valid = (state == ST_R) && m_rvalid;
    assign out_data  = m_rdata;
    assign out_last  = out_valid && burst_end && (remaining == REM_ONE);
    assign done      = (state == ST_DONE);
    assign err       = done && err_sticky;

endmodule

// File: tb/tb_axi4_full_rd_dma.sv
// Bench for axi4_full_rd_dma: randomized AXI slave, queue-based reference model, per-cycle compare.
module tb_axi4_full_rd_dma;

    localparam int AW = 32, DW = 1024, IW = 4, LW = 8, CW = 16, BYTES = 128;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0, cmd_ready;
    logic [AW-1:0] cmd_addr = '0;
    logic [CW-1:0] cmd_beats = '0;
    logic [DW-1:0] out_data;
    logic          out_last, out_valid, done, err;
    logic          out_ready = 1'b0;
    logic [IW-1:0] m_arid, m_rid = '0;
    logic [AW-1:0] m_araddr;
    logic [1:0]    m_arburst, m_rresp = 2'b00;
    logic [LW-1:0] m_arlen;
    logic [2:0]    m_arsize;
    logic          m_arvalid, m_arready = 1'b0;
    logic [DW-1:0] m_rdata = '0;
    logic          m_rlast = 1'b0, m_rvalid = 1'b0, m_rready;

    axi4_full_rd_dma dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_beats(cmd_beats), .out_data(out_data), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready), .done(done), .err(err),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arburst(m_arburst), .m_arlen(m_arlen),
        .m_arsize(m_arsize), .m_arvalid(m_arvalid), .m_arready(m_arready), .m_rid(m_rid),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid),
        .m_rready(m_rready)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int checks = 0, errors = 0;
    logic [DW-1:0] exp_q[$];
    logic          exp_last_q[$];
    logic [AW-1:0] exp_ar_addr_q[$];
    logic [LW-1:0] exp_ar_len_q[$];
    bit            exp_err = 1'b0;
    bit            done_seen = 1'b0;

    int stall_pct = 0, gap_pct = 0, ar_dmin = 0, ar_dmax = 0;
    int err_at = -1, served = 0;

    task automatic check(input string name, input bit ok, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        logic [DW-1:0] w;
        for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = (a * 32'd2654435761) ^ (32'(i) << 24) ^ 32'h1357_0000;
        return w;
    endfunction

    // Reference model: what the bursts and beats of one command must be.
    task automatic plan_cmd(input logic [AW-1:0] a, input int beats, input int e_at);
        int rem, room, b;
        logic [AW-1:0] p;
        rem = beats + 1;
        p = a;
        while (rem > 0) begin
            room = (4096 - int'(p % 4096)) / BYTES;
            b = rem;
            if (b > 16) b = 16;
            if (b > room) b = room;
            exp_ar_addr_q.push_back(p);
            exp_ar_len_q.push_back(LW'(b - 1));
            for (int k = 0; k < b; k++) begin
                exp_q.push_back(mem_word(p));
                exp_last_q.push_back(rem == 1);
                p += BYTES;
                rem--;
            end
        end
        exp_err = (e_at >= 0) && (e_at <= beats);
    endtask

    // ---------------- stream sink ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1 out_ready = ($urandom_range(0, 99) >= stall_pct);
        end
    end

    // ---------------- AXI slave ----------------
    initial begin
        bit ar_f, r_f;
        logic [AW-1:0] ar_a, s_addr;
        logic [LW-1:0] ar_l;
        int s_left, ar_wait;
        s_left = 0;
        ar_wait = -1;
        s_addr = '0;
        forever begin
            @(negedge clk);
            ar_f = m_arvalid && m_arready;
            r_f  = m_rvalid && m_rready;
            ar_a = m_araddr;
            ar_l = m_arlen;
            @(posedge clk);
            #1;
            if (rst) begin
                m_arready = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0;
                s_left = 0; ar_wait = -1;
                continue;
            end
            if (ar_f) begin
                m_arready = 1'b0;
                ar_wait = -1;
                s_addr = ar_a;
                s_left = int'(ar_l) + 1;
            end else if (m_arvalid && !m_arready) begin
                if (ar_wait < 0) ar_wait = $urandom_range(ar_dmin, ar_dmax);
                if (ar_wait == 0) m_arready = 1'b1;
                else ar_wait--;
            end
            if (r_f) begin
                served++;
                s_addr += BYTES;
                s_left--;
                m_rvalid = 1'b0;
            end
            if (s_left > 0 && !m_rvalid && $urandom_range(0, 99) >= gap_pct) begin
                m_rvalid = 1'b1;
                m_rdata  = mem_word(s_addr);
                m_rlast  = (s_left == 1);
                m_rresp  = (served == err_at) ? 2'b10 : 2'b00;
                m_rid    = '0;
            end
            if (s_left == 0) m_rvalid = 1'b0;
        end
    end

    // ---------------- compare process ----------------
    initial begin
        bit hold_v;
        logic [AW-1:0] hold_a, ea;
        logic [LW-1:0] hold_l, el;
        logic [DW-1:0] ed;
        logic          elast;
        hold_v = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_v = 1'b0;
                continue;
            end
            if (!m_arvalid && hold_v) begin
                check("ar_dropped", 1'b0, 0, 1);
                hold_v = 1'b0;
            end
            if (m_arvalid) begin
                if (hold_v) begin
                    check("ar_addr_stable", m_araddr == hold_a, m_araddr, hold_a);
                    check("ar_len_stable", m_arlen == hold_l, m_arlen, hold_l);
                end else begin
                    hold_v = 1'b1; hold_a = m_araddr; hold_l = m_arlen;
                end
                if (m_arready) begin
                    hold_v = 1'b0;
                    if (exp_ar_addr_q.size() == 0) check("ar_unexpected", 1'b0, m_araddr, 0);
                    else begin
                        ea = exp_ar_addr_q.pop_front();
                        el = exp_ar_len_q.pop_front();
                        check("ar_addr", m_araddr == ea, m_araddr, ea);
                        check("ar_len", m_arlen == el, m_arlen, el);
                        check("ar_size", m_arsize == 3'd7, m_arsize, 7);
                        check("ar_burst", m_arburst == 2'b01, m_arburst, 1);
                        check("ar_id", m_arid == '0, m_arid, 0);
                    end
                end
            end
            check("out_valid_follows", out_valid == m_rvalid, out_valid, m_rvalid);
            if (m_rvalid) check("rready_mirror", m_rready == out_ready, m_rready, out_ready);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("beat_unexpected", 1'b0, out_data[63:0], 0);
                else begin
                    ed = exp_q.pop_front();
                    elast = exp_last_q.pop_front();
                    check("out_data", out_data == ed, out_data[63:0], ed[63:0]);
                    check("out_last", out_last == elast, out_last, elast);
                end
            end
            if (done) begin
                check("done_err", err == exp_err, err, exp_err);
                check("done_beats_left", exp_q.size() == 0, exp_q.size(), 0);
                check("done_cmd_ready", cmd_ready == 1'b0, cmd_ready, 0);
                done_seen = 1'b1;
            end else begin
                check("err_without_done", err == 1'b0, err, 0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue_cmd(input logic [AW-1:0] a, input int beats, input int e_at);
        int cyc;
        err_at = e_at;
        served = 0;
        done_seen = 1'b0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_beats = CW'(beats);
        cyc = 0;
        while (1) begin
            @(negedge clk);
            if (cmd_ready) break;
            cyc++;
            if (cyc > 200) begin
                check("cmd_accept_timeout", 1'b0, 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        int cyc;
        cyc = 0;
        while (!done_seen && cyc < 5000) begin
            @(posedge clk);
            cyc++;
        end
        check("done_timeout", done_seen, done_seen, 1);
        check("ar_left", exp_ar_addr_q.size() == 0, exp_ar_addr_q.size(), 0);
    endtask

    task automatic run_cmd(input logic [AW-1:0] a, input int beats, input int e_at);
        issue_cmd(a, beats, e_at);
        wait_done();
    endtask

    task automatic flush_model();
        exp_q.delete();
        exp_last_q.delete();
        exp_ar_addr_q.delete();
        exp_ar_len_q.delete();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int cyc, nb, e;
        logic [AW-1:0] a;

        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", cmd_ready == 1'b0, cmd_ready, 0);
        check("rst_arvalid", m_arvalid == 1'b0, m_arvalid, 0);
        check("rst_rready", m_rready == 1'b0, m_rready, 0);
        check("rst_out_valid", out_valid == 1'b0, out_valid, 0);
        check("rst_done", done == 1'b0, done, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 check("idle_cmd_ready", cmd_ready == 1'b1, cmd_ready, 1);

        // single full burst
        plan_cmd(32'h0, 15, -1);
        check("pin_single_n", exp_ar_len_q.size() == 1, exp_ar_len_q.size(), 1);
        check("pin_single_len", exp_ar_len_q[0] == 8'd15, exp_ar_len_q[0], 15);
        check("pin_single_last", exp_last_q[15] == 1'b1 && exp_last_q[14] == 1'b0, exp_last_q[15], 1);
        run_cmd(32'h0, 15, -1);

        // 4 KiB split
        plan_cmd(32'hF80, 3, -1);
        check("pin_f80_n", exp_ar_len_q.size() == 2, exp_ar_len_q.size(), 2);
        check("pin_f80_len0", exp_ar_len_q[0] == 8'd0, exp_ar_len_q[0], 0);
        check("pin_f80_addr1", exp_ar_addr_q[1] == 32'h1000, exp_ar_addr_q[1], 32'h1000);
        check("pin_f80_len1", exp_ar_len_q[1] == 8'd2, exp_ar_len_q[1], 2);
        run_cmd(32'hF80, 3, -1);

        // three bursts
        plan_cmd(32'h0, 39, -1);
        check("pin_40_n", exp_ar_len_q.size() == 3, exp_ar_len_q.size(), 3);
        check("pin_40_addr1", exp_ar_addr_q[1] == 32'h800, exp_ar_addr_q[1], 32'h800);
        check("pin_40_addr2", exp_ar_addr_q[2] == 32'h1000, exp_ar_addr_q[2], 32'h1000);
        check("pin_40_len2", exp_ar_len_q[2] == 8'd7, exp_ar_len_q[2], 7);
        run_cmd(32'h0, 39, -1);

        // single beat
        plan_cmd(32'h2080, 0, -1);
        run_cmd(32'h2080, 0, -1);

        // stalls and slow AR
        stall_pct = 40; gap_pct = 30; ar_dmin = 5; ar_dmax = 5;
        plan_cmd(32'h200, 30, -1);
        run_cmd(32'h200, 30, -1);

        // slave error on beat 3 of 8, then a clean command
        stall_pct = 20; gap_pct = 20; ar_dmin = 0; ar_dmax = 2;
        plan_cmd(32'h0, 7, 2);
        check("pin_err_flag", exp_err == 1'b1, exp_err, 1);
        run_cmd(32'h0, 7, 2);
        plan_cmd(32'h400, 7, -1);
        run_cmd(32'h400, 7, -1);

        // randomized commands
        for (int t = 0; t < 12; t++) begin
            a  = AW'($urandom_range(0, 127)) * BYTES;
            nb = $urandom_range(0, 40);
            e  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, nb) : -1;
            stall_pct = $urandom_range(0, 50);
            gap_pct   = $urandom_range(0, 50);
            ar_dmin   = 0;
            ar_dmax   = $urandom_range(0, 5);
            plan_cmd(a, nb, e);
            run_cmd(a, nb, e);
        end

        // reset in the middle of a burst
        stall_pct = 0; gap_pct = 0; ar_dmin = 0; ar_dmax = 0;
        plan_cmd(32'h0, 60, -1);
        issue_cmd(32'h0, 60, -1);
        cyc = 0;
        while (exp_q.size() > 55 && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        check("mid_reset_reach", exp_q.size() <= 55, exp_q.size(), 55);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_arvalid", m_arvalid == 1'b0, m_arvalid, 0);
        check("mid_rst_rready", m_rready == 1'b0, m_rready, 0);
        check("mid_rst_cmd_ready", cmd_ready == 1'b0, cmd_ready, 0);
        check("mid_rst_out_valid", out_valid == 1'b0, out_valid, 0);
        repeat (3) @(posedge clk);
        flush_model();
        #1 rst = 1'b0;
        cyc = 0;
        while (cyc < 20) begin
            @(negedge clk);
            if (cmd_ready) break;
            cyc++;
        end
        check("post_rst_cmd_ready", cmd_ready == 1'b1, cmd_ready, 1);

        plan_cmd(32'hF00, 5, -1);
        run_cmd(32'hF00, 5, -1);

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
